// File: rtl/nios2_keyout.sv
// Avalon-MM output PIO: static write, bitwise set/clear and a timed one-shot pulse on out_port.
// Readback is registered with one cycle of latency and no wait states.
module nios2_keyout #(
    parameter int unsigned      WIDTH        = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter int unsigned      PULSE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address_i,
    input  logic             chipselect_i,
    input  logic             write_n_i,
    input  logic [31:0]      writedata_i,
    output logic [31:0]      readdata_o,
    output logic [WIDTH-1:0] out_port_o
);

    localparam int unsigned     CntW    = $clog2(PULSE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(PULSE_CYCLES - 1);

    typedef enum logic {StIdle, StPulsing} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;

    logic             wr, wr_data, wr_pulse, expire, busy;
    logic [WIDTH-1:0] w, out_w, mask_w;

    assign wr       = chipselect_i & ~write_n_i;
    assign w        = writedata_i[WIDTH-1:0];
    assign wr_data  = wr && (address_i == 2'd0);
    assign wr_pulse = wr && (address_i == 2'd1);
    assign busy     = (state_q == StPulsing);

    // DATA and PULSE writes override a simultaneous expiry; OUTSET/OUTCLEAR do not.
    assign expire = busy && (cnt_q == '0) && !wr_data && !wr_pulse;

    // Register-write effect on out/mask, before any expiry clear.
    always_comb begin
        out_w  = out_q;
        mask_w = mask_q;
        if (wr) begin
            case (address_i)
                2'd0: begin
                    out_w  = w;
                    mask_w = '0;
                end
                2'd1: begin
                    out_w  = out_q | w;
                    mask_w = mask_q | w;
                end
                2'd2: begin
                    out_w  = out_q | w;
                    mask_w = mask_q & ~w;
                end
                default: begin
                    out_w  = out_q & ~w;
                    mask_w = mask_q & ~w;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            out_q   <= RESET_VALUE;
            mask_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (wr_pulse) begin
                    state_d = StPulsing;
                end
            end
            StPulsing: begin
                if (wr_data) begin
                    state_d = StIdle;
                end else if (wr_pulse) begin
                    state_d = StPulsing;
                end else if (expire || (mask_w == '0)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_d   = out_w;
        mask_d  = mask_w;
        cnt_d   = cnt_q;
        rdata_d = '0;

        if (expire) begin
            out_d  = out_w & ~mask_w;
            mask_d = '0;
        end

        if (state_d == StIdle) begin
            cnt_d = '0;
        end else if (wr_pulse) begin
            cnt_d = CntLoad;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end

        // Readback samples pre-write state.
        case (address_i)
            2'd0: rdata_d[WIDTH-1:0] = out_q;
            2'd1: begin
                rdata_d[WIDTH-1:0] = mask_q;
                rdata_d[31]        = busy;
            end
            default: rdata_d = '0;
        endcase
    end

    assign out_port_o = out_q;
    assign readdata_o = rdata_q;

endmodule
